// File: rtl/dht11_sensor_emulator.sv
// dht11_sensor_emulator: sensor side of the DHT11 single-wire protocol.
// Answers a valid host start with the response preamble and a 40-bit frame, timed in 1 us ticks.
module dht11_sensor_emulator #(
    parameter int START_MIN = 1000,
    parameter int RESP_WAIT = 30,
    parameter int RESP_LOW  = 80,
    parameter int RESP_HIGH = 80,
    parameter int BIT_LOW   = 50,
    parameter int BIT0_HIGH = 26,
    parameter int BIT1_HIGH = 70,
    parameter int END_LOW   = 50,
    parameter int TIMEOUT   = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    inout  wire        dht_io,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    input  logic       inject_err,
    output logic       busy,
    output logic       frame_done,
    output logic       start_err,
    output logic [3:0] state_dbg
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, HOST_LOW, HOST_REL, RESP_L, RESP_H, BIT_L, BIT_H, END_L} state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          line, prev, oe, done;
    logic [CW-1:0] cnt, lim;
    logic [5:0]    bit_idx;
    logic [39:0]   shift;
    logic [7:0]    cks;

    assign dht_io    = oe ? 1'b0 : 1'bz;
    assign line      = sync[1];
    assign state_dbg = {busy, state};
    assign cks       = (hum_int + hum_dec + temp_int + temp_dec) ^ {7'd0, inject_err};

    // Terminal count of the current timed phase; a phase ends on the tick that reaches it.
    assign lim = state == HOST_REL ? CW'(RESP_WAIT - 1)
               : state == RESP_L   ? CW'(RESP_LOW - 1)
               : state == RESP_H   ? CW'(RESP_HIGH - 1)
               : state == BIT_L    ? CW'(BIT_LOW - 1)
               : state == BIT_H    ? (shift[39] ? CW'(BIT1_HIGH - 1) : CW'(BIT0_HIGH - 1))
               : CW'(END_LOW - 1);
    assign done = tick && cnt == lim;

    // prev resets low so a line already held low out of reset never looks like a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync       <= '0;
            prev       <= 1'b0;
            state      <= IDLE;
            oe         <= 1'b0;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            start_err  <= 1'b0;
        end else begin
            sync       <= {sync[0], dht_io};
            prev       <= line;
            frame_done <= 1'b0;
            start_err  <= 1'b0;
            if (tick && state > HOST_LOW)
                cnt <= done ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (prev && !line) begin
                        state <= HOST_LOW;
                        cnt   <= '0;
                    end
                end
                HOST_LOW: begin
                    if (line) begin
                        cnt       <= '0;
                        state     <= cnt >= CW'(START_MIN) ? HOST_REL : IDLE;
                        busy      <= cnt >= CW'(START_MIN);
                        start_err <= cnt < CW'(START_MIN);
                    end else if (tick && cnt != CW'(TIMEOUT)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOST_REL: begin
                    if (!line) begin
                        state <= HOST_LOW;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (done) begin
                        shift <= {hum_int, hum_dec, temp_int, temp_dec, cks};
                        oe    <= 1'b1;
                        state <= RESP_L;
                    end
                end
                RESP_L: begin
                    if (done) begin
                        oe    <= 1'b0;
                        state <= RESP_H;
                    end
                end
                RESP_H: begin
                    if (done) begin
                        oe      <= 1'b1;
                        bit_idx <= '0;
                        state   <= BIT_L;
                    end
                end
                BIT_L: begin
                    if (done) begin
                        oe    <= 1'b0;
                        state <= BIT_H;
                    end
                end
                BIT_H: begin
                    if (done) begin
                        shift   <= {shift[38:0], 1'b0};
                        bit_idx <= bit_idx + 1'b1;
                        oe      <= 1'b1;
                        state   <= bit_idx == 6'd39 ? END_L : BIT_L;
                    end
                end
                END_L: begin
                    if (done) begin
                        oe         <= 1'b0;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dht11_sensor_emulator.sv
// tb_dht11_sensor_emulator: drives host start pulses and checks every line segment of the
// emulator's reply against a waveform built from the frame bytes.
module tb_dht11_sensor_emulator;
    localparam int RESP_WAIT = 30, RESP_LOW = 80, RESP_HIGH = 80, BIT_LOW = 50;
    localparam int BIT0_HIGH = 26, BIT1_HIGH = 70, END_LOW = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       host_low = 1'b0;
    logic       inject_err = 1'b0;
    logic [7:0] hum_int = '0, hum_dec = '0, temp_int = '0, temp_dec = '0;
    logic       busy, frame_done, start_err;
    logic [3:0] state_dbg;
    wire        dht_io;

    int          checks = 0, errors = 0;
    int          n_done = 0, n_serr = 0, n_busy = 0, n_low = 0;
    int          exp_lvl[$], exp_min[$], exp_max[$], exp_tag[$];
    logic [39:0] decoded;
    bit          cmp_on = 1'b0;

    assign dht_io = host_low ? 1'b0 : 1'bz;
    pullup pu (dht_io);

    dht11_sensor_emulator dut (
        .clk(clk), .reset(reset), .tick(tick), .dht_io(dht_io),
        .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
        .inject_err(inject_err), .busy(busy), .frame_done(frame_done),
        .start_err(start_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        tick = ~tick;
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [39:0] model_frame(input logic [7:0] a, b, c, d, input logic inj);
        int s;
        s = (int'(a) + int'(b) + int'(c) + int'(d)) % 256;
        if (inj) s = s ^ 1;
        return {a, b, c, d, 8'(s)};
    endfunction

    task automatic push_seg(input int lvl, input int mn, input int mx, input int tg);
        exp_lvl.push_back(lvl);
        exp_min.push_back(mn);
        exp_max.push_back(mx);
        exp_tag.push_back(tg);
    endtask

    task automatic plan_frame(input logic [39:0] fr, input int host_len);
        int h;
        exp_lvl.delete();
        exp_min.delete();
        exp_max.delete();
        exp_tag.delete();
        push_seg(1, 0, 1 << 30, -1);
        push_seg(0, host_len - 1, host_len + 1, -1);
        push_seg(1, RESP_WAIT, RESP_WAIT + 2, -1);
        push_seg(0, RESP_LOW, RESP_LOW, -1);
        push_seg(1, RESP_HIGH, RESP_HIGH, -1);
        for (int i = 0; i < 40; i++) begin
            h = fr[39 - i] ? BIT1_HIGH : BIT0_HIGH;
            push_seg(0, BIT_LOW, BIT_LOW, -1);
            push_seg(1, h, h, i);
        end
        push_seg(0, END_LOW, END_LOW, -1);
    endtask

    task automatic compare_seg(input int lvl, input int len);
        int el, mn, mx, tg;
        checks++;
        if (exp_lvl.size() == 0) begin
            errors++;
            $display("FAIL segment_extra: level %0d for %0d ticks, none expected", lvl, len);
            return;
        end
        el = exp_lvl.pop_front();
        mn = exp_min.pop_front();
        mx = exp_max.pop_front();
        tg = exp_tag.pop_front();
        if (lvl != el || len < mn || len > mx) begin
            errors++;
            $display("FAIL segment bit %0d: level %0d for %0d ticks, expected level %0d for %0d..%0d ticks",
                     tg, lvl, len, el, mn, mx);
        end
        if (tg >= 0) decoded = {decoded[38:0], len > (BIT0_HIGH + BIT1_HIGH) / 2};
    endtask

    task automatic host_start(input int len);
        int n;
        n = 0;
        @(negedge clk);
        host_low = 1'b1;
        while (n < len) begin
            @(posedge clk);
            if (tick) n++;
        end
        @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic run_frame(input int a, b, c, d, input bit inj, input int host_len, input int cks);
        logic [39:0] fr;
        int d0;
        hum_int = 8'(a);
        hum_dec = 8'(b);
        temp_int = 8'(c);
        temp_dec = 8'(d);
        inject_err = inj;
        fr = model_frame(8'(a), 8'(b), 8'(c), 8'(d), inj);
        check("model_cks", int'(fr[7:0]), cks);
        plan_frame(fr, host_len);
        decoded = '0;
        d0 = n_done;
        cmp_on = 1'b1;
        host_start(host_len);
        // Inputs change after the frame is latched; the reply must not follow them.
        repeat (200) @(posedge clk);
        hum_int = ~hum_int;
        hum_dec = ~hum_dec;
        temp_int = ~temp_int;
        temp_dec = ~temp_dec;
        inject_err = ~inject_err;
        for (int i = 0; i < 20000 && n_done == d0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        cmp_on = 1'b0;
        check("segments_left", exp_lvl.size(), 0);
        check("frame_done_count", n_done - d0, 1);
        check("busy_after_frame", int'(busy), 0);
        check("byte_hum_int", int'(decoded[39:32]), a);
        check("byte_hum_dec", int'(decoded[31:24]), b);
        check("byte_temp_int", int'(decoded[23:16]), c);
        check("byte_temp_dec", int'(decoded[15:8]), d);
        check("byte_cks", int'(decoded[7:0]), cks);
        inject_err = 1'b0;
    endtask

    initial begin
        int seg, last, lvl, found, hits, was, cur, s0, b0, l0;
        seg = 0;
        last = 1;
        fork
            forever begin
                @(posedge clk);
                if (tick) seg++;
                #1;
                lvl = (dht_io === 1'b0) ? 0 : 1;
                if (start_err) n_serr++;
                if (frame_done) n_done++;
                if (busy) n_busy++;
                if (lvl == 0) n_low++;
                if (lvl != last) begin
                    if (cmp_on) compare_seg(last, seg);
                    last = lvl;
                    seg = 0;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #2;
        check("reset_state_dbg", int'(state_dbg), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_start_err", int'(start_err), 0);
        check("reset_line_released", int'(dht_io !== 1'b0), 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);

        run_frame(8'h37, 8'h00, 8'h18, 8'h00, 1'b0, 1800, 8'h4F);
        run_frame(8'h37, 8'h00, 8'h18, 8'h00, 1'b1, 1200, 8'h4E);
        run_frame(8'hFF, 8'hFF, 8'h02, 8'h03, 1'b0, 1200, 8'h03);

        s0 = n_serr;
        b0 = n_busy;
        host_start(500);
        l0 = n_low;
        repeat (300) @(posedge clk);
        #2;
        check("short_start_err_pulses", n_serr - s0, 1);
        check("short_busy_cycles", n_busy - b0, 0);
        check("short_line_driven", n_low - l0, 0);
        check("short_state_dbg", int'(state_dbg), 0);

        host_start(1100);
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            @(posedge clk);
            #1;
            found = (state_dbg == 4'hB) ? 1 : 0;
        end
        check("reach_resp_l", found, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("resp_l_reset_line_released", int'(dht_io !== 1'b0), 1);
        check("resp_l_reset_state_dbg", int'(state_dbg), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);

        host_start(1100);
        hits = 0;
        was = 0;
        for (int i = 0; i < 12000 && hits < 13; i++) begin
            @(posedge clk);
            #1;
            cur = (state_dbg == 4'hE) ? 1 : 0;
            if (cur == 1 && was == 0) hits++;
            was = cur;
        end
        check("reach_bit12_high", hits, 13);
        #2;
        reset = 1'b1;
        #1;
        check("bit12_reset_line_released", int'(dht_io !== 1'b0), 1);
        check("bit12_reset_state_dbg", int'(state_dbg), 0);
        check("bit12_reset_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(posedge clk);

        run_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 1100, 8'h14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
